// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM (optional jal via MC_JAL_EN)
module mc_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWrite,
   output logic [1:0] NPCOp,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] WDSel,
   output logic       ALUSrc,
   output logic [1:0] ALUOp,
   output logic [1:0] EXTOp,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MA     = 4'd2,
      S_MR     = 4'd3,
      S_MWB    = 4'd4,
      S_MW     = 4'd5,
      S_EXE    = 4'd6,
      S_AWB    = 4'd7,
      S_BR     = 4'd8,
      S_JMP    = 4'd9
   } state_t;

   state_t cur, nxt;

   logic is_lw, is_sw, is_r, is_addu, is_subu, is_ori, is_lui, is_beq, is_j, is_jal;

   assign is_lw   = (op == 6'b100011);
   assign is_sw   = (op == 6'b101011);
   assign is_r    = (op == 6'b000000);
   assign is_addu = is_r && (funct == 6'b100001);
   assign is_subu = is_r && (funct == 6'b100011);
   assign is_ori  = (op == 6'b001101);
   assign is_lui  = (op == 6'b001111);
   assign is_beq  = (op == 6'b000100);
   assign is_j    = (op == 6'b000010);
`ifdef MC_JAL_EN
   assign is_jal  = (op == 6'b000011);
`else
   // Without jal support the opcode falls through to the unsupported path.
   assign is_jal  = 1'b0;
`endif

   assign state = cur;

   // State register; reset returns to FETCH from anywhere, including mid-instruction.
   always_ff @(posedge clk) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   // Next-state and Moore outputs; only BR's PCWrite looks at a live input (zero).
   always_comb begin
      nxt      = S_FETCH;
      PCWrite  = 1'b0;
      NPCOp    = 2'b00;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 2'b00;
      WDSel    = 2'b00;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;
      EXTOp    = 2'b00;
      illegal  = 1'b0;
      case (cur)
         S_FETCH: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            nxt     = S_DECODE;
         end
         S_DECODE: begin
            if (is_lw || is_sw)                         nxt = S_MA;
            else if (is_addu || is_subu || is_ori || is_lui) nxt = S_EXE;
            else if (is_beq)                            nxt = S_BR;
            else if (is_j || is_jal)                    nxt = S_JMP;
            else begin
               nxt     = S_FETCH;
               illegal = 1'b1;
            end
         end
         S_MA: begin
            ALUSrc = 1'b1;
            EXTOp  = 2'b01;
            nxt    = is_lw ? S_MR : S_MW;
         end
         S_MR: nxt = S_MWB;
         S_MWB: begin
            RegWrite = 1'b1;
            WDSel    = 2'b01;
         end
         S_MW: begin
            MemWrite = 1'b1;
            ALUSrc   = 1'b1;
            EXTOp    = 2'b01;
         end
         S_EXE, S_AWB: begin
            // AWB keeps the EXE datapath selects so the ALU result stays valid.
            if (is_subu) ALUOp = 2'b01;
            if (is_ori) begin
               ALUSrc = 1'b1;
               ALUOp  = 2'b10;
            end
            if (is_lui) begin
               ALUSrc = 1'b1;
               EXTOp  = 2'b10;
               ALUOp  = 2'b10;
            end
            if (cur == S_AWB) begin
               RegWrite = 1'b1;
               RegDst   = is_r ? 2'b01 : 2'b00;
            end else begin
               nxt = S_AWB;
            end
         end
         S_BR: begin
            ALUOp   = 2'b01;
            NPCOp   = 2'b01;
            PCWrite = zero;
         end
         S_JMP: begin
            PCWrite = 1'b1;
            NPCOp   = 2'b10;
            if (is_jal) begin
               // PC was already advanced in FETCH, so it holds the link address.
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               WDSel    = 2'b10;
            end
         end
         default: nxt = S_FETCH;
      endcase
      if (rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against a per-instruction cycle model
module tb_mc_ctrl;

   logic       clk, rst, zero;
   logic [5:0] op, funct;
   logic       PCWrite, IRWrite, MemWrite, RegWrite, ALUSrc, illegal;
   logic [1:0] NPCOp, RegDst, WDSel, ALUOp, EXTOp;
   logic [3:0] state;
   logic [19:0] act;

   int n_checks = 0;
   int n_fail   = 0;

   logic [19:0] exp_seq [8];
   int          exp_n;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .PCWrite(PCWrite), .NPCOp(NPCOp), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrc(ALUSrc),
      .ALUOp(ALUOp), .EXTOp(EXTOp), .illegal(illegal), .state(state)
   );

   assign act = {PCWrite, NPCOp, IRWrite, MemWrite, RegWrite, RegDst, WDSel,
                 ALUSrc, ALUOp, EXTOp, illegal, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, input logic [1:0] npc,
                                      input logic irw, input logic mw, input logic rw,
                                      input logic [1:0] rd, input logic [1:0] wd, input logic as,
                                      input logic [1:0] aop, input logic [1:0] ext, input logic ill);
      return {pcw, npc, irw, mw, rw, rd, wd, as, aop, ext, ill, st};
   endfunction

   task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Reference: the cycle-by-cycle output list an instruction should produce.
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z);
      logic jal_ok;
`ifdef MC_JAL_EN
      jal_ok = 1'b1;
`else
      jal_ok = 1'b0;
`endif
      exp_seq[0] = mk(4'd0, 1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      exp_seq[1] = mk(4'd1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      exp_n = 2;
      if (o == 6'b100011) begin
         exp_seq[2] = mk(4'd2, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0);
         exp_seq[3] = mk(4'd3, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
         exp_seq[4] = mk(4'd4, 0, 2'b00, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0);
         exp_n = 5;
      end else if (o == 6'b101011) begin
         exp_seq[2] = mk(4'd2, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0);
         exp_seq[3] = mk(4'd5, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0);
         exp_n = 4;
      end else if (o == 6'b000000 && (f == 6'b100001 || f == 6'b100011)) begin
         exp_seq[2] = mk(4'd6, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, {1'b0, f[1]}, 2'b00, 0);
         exp_seq[3] = mk(4'd7, 0, 2'b00, 0, 0, 1, 2'b01, 2'b00, 0, {1'b0, f[1]}, 2'b00, 0);
         exp_n = 4;
      end else if (o == 6'b001101 || o == 6'b001111) begin
         exp_seq[2] = mk(4'd6, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, {o[1], 1'b0}, 0);
         exp_seq[3] = mk(4'd7, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 1, 2'b10, {o[1], 1'b0}, 0);
         exp_n = 4;
      end else if (o == 6'b000100) begin
         exp_seq[2] = mk(4'd8, z, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
         exp_n = 3;
      end else if (o == 6'b000010) begin
         exp_seq[2] = mk(4'd9, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
         exp_n = 3;
      end else if (o == 6'b000011 && jal_ok) begin
         exp_seq[2] = mk(4'd9, 1, 2'b10, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 0);
         exp_n = 3;
      end else begin
         exp_seq[1] = mk(4'd1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1);
      end
   endtask

   // Entered shortly after a rising edge with the DUT in FETCH; leaves it the same way.
   task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int want_n);
      int n;
      build(o, f, z);
      op = o; funct = f; zero = z;
      n = 0;
      do begin
         #1;
         if (n < exp_n) check(name, act, exp_seq[n]);
         else check({name, "_overrun"}, act, exp_seq[0]);
         n++;
         @(posedge clk); #1;
      end while (state != 4'd0 && n < 8);
      check({name, "_cycles"}, 20'(n), 20'(want_n < 0 ? exp_n : want_n));
   endtask

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      int         cycles;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int jal_cycles;
`ifdef MC_JAL_EN
      jal_cycles = 3;
`else
      jal_cycles = 2;
`endif
      tbl[0]  = '{"lw",    6'b100011, 6'b010101, 1'b0, 5};
      tbl[1]  = '{"sw",    6'b101011, 6'b000000, 1'b1, 4};
      tbl[2]  = '{"addu",  6'b000000, 6'b100001, 1'b0, 4};
      tbl[3]  = '{"subu",  6'b000000, 6'b100011, 1'b1, 4};
      tbl[4]  = '{"ori",   6'b001101, 6'b100001, 1'b0, 4};
      tbl[5]  = '{"lui",   6'b001111, 6'b000000, 1'b0, 4};
      tbl[6]  = '{"beq_t", 6'b000100, 6'b000000, 1'b1, 3};
      tbl[7]  = '{"beq_n", 6'b000100, 6'b000000, 1'b0, 3};
      tbl[8]  = '{"j",     6'b000010, 6'b000000, 1'b0, 3};
      tbl[9]  = '{"jal",   6'b000011, 6'b000000, 1'b0, jal_cycles};
      tbl[10] = '{"r_ill", 6'b000000, 6'b000000, 1'b0, 2};
      tbl[11] = '{"op_ill",6'b111111, 6'b100001, 1'b1, 2};

      rst = 1'b1; op = '0; funct = '0; zero = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_hold", act, 20'h0);
      rst = 1'b0; #1;
      check("rst_release", act, mk(4'd0, 1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));

      for (int i = 0; i < 12; i++)
         run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].cycles);

      // Reset held two cycles while sitting in MR.
      op = 6'b100011; funct = '0; zero = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("mr_reached", 20'(state), 20'd3);
      rst = 1'b1; #1;
      check("rst_in_mr", act, mk(4'd3, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
      @(posedge clk); #1;
      check("rst_mr_edge1", act, 20'h0);
      @(posedge clk); #1;
      check("rst_mr_edge2", act, 20'h0);
      rst = 1'b0; #1;
      check("rst_mr_release", act, mk(4'd0, 1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));

      // Reset asserted in MWB masks RegWrite combinationally.
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1; #1;
      check("rst_in_mwb", act, mk(4'd4, 0, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0));
      @(posedge clk); #1;
      check("rst_mwb_edge", 20'(state), 20'd0);
      rst = 1'b0;

      // PCWrite follows zero combinationally while in BR.
      op = 6'b000100; zero = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("br_zero0", 20'({PCWrite, state}), 20'h08);
      zero = 1'b1; #1;
      check("br_zero1", 20'({PCWrite, state}), 20'h18);
      @(posedge clk); #1;
      check("br_to_fetch", 20'(state), 20'd0);

      for (int i = 0; i < 150; i++) begin
         logic [5:0] o, f;
         logic       z;
         case ($urandom_range(0, 9))
            0: o = 6'b100011;
            1: o = 6'b101011;
            2, 3: o = 6'b000000;
            4: o = 6'b001101;
            5: o = 6'b001111;
            6: o = 6'b000100;
            7: o = 6'b000010;
            8: o = 6'b000011;
            default: o = 6'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0: f = 6'b100001;
            1: f = 6'b100011;
            default: f = 6'($urandom);
         endcase
         z = 1'($urandom);
         run_instr("rand", o, f, z, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
